// File: rtl/result_uart_tx.sv
// Purpose: watch the machine's result byte, queue each new value, and send it as 8N1 UART frames on tx.
// Latency: a byte that changes before edge k is queued at edge k; tx falls after edge k+1 if the line was idle.
// Backpressure: none upstream; a changed byte arriving while the queue is full is dropped and flagged in overflow.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    // Pointer, count and bit-timer widths.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Change-detect registers.
    logic [7:0]    prev_q;
    logic          prev_valid_q;

    // Queue storage and bookkeeping.
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Serialiser state.
    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;

    // Per-cycle handshake between change detect, queue and serialiser.
    logic          push_req;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [7:0]    head_dat;

    // Decide this edge's push/pop and the queue's next bookkeeping values.
    always_comb begin
        push_req   = !prev_valid_q || (data_in != prev_q);
        fifo_full  = (count_q == FULL_CNT);
        // The serialiser only pulls a byte while idle, and never from an empty queue.
        pop        = (state_q == IDLE) && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push_ok    = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
        head_dat   = mem_q[rd_ptr_q];

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || drop;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Remember the last sampled byte; every sample counts, dropped or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q       <= 8'h00;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= data_in;
            prev_valid_q <= 1'b1;
        end
    end

    // Queue pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Queue storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Frame serialiser: start bit, eight data bits LSB first, stop bit; tx and busy registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (pop) begin
                        shift_q   <= head_dat;
                        bit_cnt_q <= 3'd0;
                        timer_q   <= TIMER_MAX;
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (timer_q == '0) begin
                        timer_q <= TIMER_MAX;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                DATA: begin
                    if (timer_q == '0) begin
                        timer_q <= TIMER_MAX;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            // Next bit is already sitting one position up.
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                STOP: begin
                    if (timer_q == '0) begin
                        // One idle cycle always separates frames: the pop happens from IDLE.
                        timer_q <= TIMER_MAX;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Purpose: exercise result_uart_tx against a frame-timing reference model with directed and random data.
// Latency: outputs are compared 1 time unit after every rising clock edge.
// Backpressure: not applicable; the design has no ready input.
module tb_result_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a byte queue plus "cycles since the current frame began".
    logic [7:0] m_q[$];
    logic       m_act;
    int         m_el;
    logic [7:0] m_fb;
    logic [7:0] m_prev;
    logic       m_pv;
    logic       m_ovf;
    int         m_frames;

    result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected tx from elapsed frame time: start bit, 8 data bits LSB first, stop bit.
    function automatic logic exp_tx();
        if (!m_act)            return 1'b1;
        if (m_el < CPB)        return 1'b0;
        if (m_el < 9 * CPB)    return m_fb[(m_el / CPB) - 1];
        return 1'b1;
    endfunction

    // Apply inputs for one edge, advance the model, then compare all outputs.
    task automatic cycle(input logic r, input logic [7:0] d);
        logic pop;
        logic push;
        reset   = r;
        data_in = d;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_act = 1'b0;
            m_el  = 0;
            m_pv  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            pop  = !m_act && (m_q.size() != 0);
            push = !m_pv || (d != m_prev);
            if (m_act) begin
                m_el++;
                if (m_el == 10 * CPB) m_act = 1'b0;
            end
            if (pop) begin
                m_fb  = m_q.pop_front();
                m_act = 1'b1;
                m_el  = 0;
                m_frames++;
            end
            if (push) begin
                if (m_q.size() == DEPTH) m_ovf = 1'b1;
                else m_q.push_back(d);
            end
            m_prev = d;
            m_pv   = 1'b1;
        end
        #1;
        chk("tx",         {7'd0, tx},   {7'd0, exp_tx()});
        chk("busy",       {7'd0, busy}, {7'd0, m_act});
        chk("fifo_count", {5'd0, fifo_count}, 8'(m_q.size()));
        chk("overflow",   {7'd0, overflow}, {7'd0, m_ovf});
    endtask

    // Hold the input until the model has drained everything (bounded).
    task automatic drain(input logic [7:0] d);
        for (int i = 0; i < 20 * 10 * CPB; i++) begin
            if (!m_act && m_q.size() == 0) break;
            cycle(1'b0, d);
        end
    endtask

    initial begin
        logic [7:0] base;
        logic [7:0] cur;
        int         f0;
        m_act = 1'b0; m_el = 0; m_fb = 8'h00; m_prev = 8'h00;
        m_pv = 1'b0; m_ovf = 1'b0; m_frames = 0;
        reset = 1'b1;
        data_in = 8'h00;
        #1;

        // Reset state.
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'hA5);

        // 1: held A5 produces exactly one frame.
        f0 = m_frames;
        for (int i = 0; i < 12 * CPB; i++) cycle(1'b0, 8'hA5);
        chk("t1_frames", 8'(m_frames - f0), 8'd1);
        chk("t1_idle_tx", {7'd0, tx}, 8'd1);

        // 2: two consecutive values give two frames.
        f0 = m_frames;
        cycle(1'b0, 8'h01);
        cycle(1'b0, 8'h02);
        drain(8'h02);
        cycle(1'b0, 8'h02);
        chk("t2_frames", 8'(m_frames - f0), 8'd2);

        // 3: six distinct values during a frame -> four queued, overflow sticky.
        f0 = m_frames;
        base = 8'($urandom);
        cycle(1'b0, base);
        for (int i = 1; i <= 6; i++) cycle(1'b0, base + 8'(i));
        chk("t3_ovf_set", {7'd0, overflow}, 8'd1);
        drain(base + 8'd6);
        for (int i = 0; i < 3; i++) cycle(1'b0, base + 8'd6);
        chk("t3_frames", 8'(m_frames - f0), 8'd5);
        chk("t3_ovf_sticky", {7'd0, overflow}, 8'd1);

        // 4: full queue, FSM idle in pop cycle, new value accepted.
        cycle(1'b1, 8'h00);
        base = 8'($urandom);
        cycle(1'b0, base);
        for (int i = 1; i <= 4; i++) cycle(1'b0, base ^ 8'(i));
        cur = base ^ 8'd4;
        for (int i = 0; i < 12 * CPB && m_act; i++) cycle(1'b0, cur);
        cycle(1'b0, ~cur);
        chk("t4_count", {5'd0, fifo_count}, 8'd4);
        chk("t4_ovf", {7'd0, overflow}, 8'd0);
        drain(~cur);

        // 5: reset during data bit 3, then current value is resent.
        cur = 8'($urandom);
        cycle(1'b0, cur);
        for (int i = 0; i < 12 * CPB && !(m_act && m_el == 4 * CPB + 1); i++) cycle(1'b0, cur);
        cycle(1'b1, cur);
        chk("t5_tx", {7'd0, tx}, 8'd1);
        chk("t5_busy", {7'd0, busy}, 8'd0);
        chk("t5_count", {5'd0, fifo_count}, 8'd0);
        f0 = m_frames;
        cycle(1'b0, cur);
        drain(cur);
        chk("t5_resend", 8'(m_frames - f0), 8'd1);

        // 6: 300 constant cycles, no spurious frames.
        f0 = m_frames;
        for (int i = 0; i < 300; i++) cycle(1'b0, cur);
        chk("t6_frames", 8'(m_frames - f0), 8'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cur = 8'($urandom);
            cycle($urandom_range(0, 599) == 0, cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
